// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, ALU operand/result bus, writeback and debug read signals
// shared between the issue sequencer and its environment.
interface alu_issue_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic [DW-1:0] alu_data1;
    logic [DW-1:0] alu_data2;
    logic [2:0]    alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          zero_flag;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    modport master (
        output instr_valid, instr, alu_result, dbg_addr,
        input  instr_ready, alu_data1, alu_data2, alu_ctrl,
               wb_valid, wb_addr, wb_data, zero_flag, dbg_data
    );

    modport slave (
        input  instr_valid, instr, alu_result, dbg_addr,
        output instr_ready, alu_data1, alu_data2, alu_ctrl,
               wb_valid, wb_addr, wb_data, zero_flag, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue/writeback sequencer: accepts a register-format instruction,
// reads operands from an 8x16 register file, drives the external ALU and writes back.
module alu_issue_ctrl #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t        state_reg, state_next;
    logic          ready_next;
    logic          wb_valid_next;
    logic [15:0]   instr_reg;
    logic [DW-1:0] rf_reg [NREG];
    logic [DW-1:0] data1_reg, data2_reg, result_reg;
    logic [2:0]    ctrl_reg;
    logic [AW-1:0] wb_addr_reg;
    logic          zero_reg;

    logic [2:0]    op_f;
    logic [AW-1:0] rd_f, rs_f, rt_f;
    logic          imm_sel_f;
    logic [5:0]    imm6_f;

    assign op_f      = instr_reg[15:13];
    assign rd_f      = instr_reg[12:10];
    assign rs_f      = instr_reg[9:7];
    assign imm_sel_f = instr_reg[6];
    assign rt_f      = instr_reg[5:3];
    assign imm6_f    = instr_reg[5:0];

    // R0 is hardwired to zero regardless of the array contents
    function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
        return (a == '0) ? '0 : rf_reg[a];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ready_next    = 1'b0;
        wb_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (bus.instr_valid) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC:   state_next = WB;
            WB: begin
                wb_valid_next = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_reg   <= '0;
            data1_reg   <= '0;
            data2_reg   <= '0;
            ctrl_reg    <= '0;
            result_reg  <= '0;
            wb_addr_reg <= '0;
            zero_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (bus.instr_valid) instr_reg <= bus.instr;
                DECODE: begin
                    data1_reg <= rf_read(rs_f);
                    data2_reg <= imm_sel_f ? {{(DW-6){1'b0}}, imm6_f} : rf_read(rt_f);
                    ctrl_reg  <= op_f;
                end
                EXEC: begin
                    result_reg  <= bus.alu_result;
                    wb_addr_reg <= rd_f;
                end
                WB:      zero_reg <= (result_reg == '0);
                default: ;
            endcase
        end
    end

    // Entry 0 is cleared by reset and never written, so it stays zero too
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
        end else if (state_reg == WB && rd_f != '0) begin
            rf_reg[rd_f] <= result_reg;
        end
    end

    assign bus.instr_ready = ready_next;
    assign bus.wb_valid    = wb_valid_next;
    assign bus.alu_data1   = data1_reg;
    assign bus.alu_data2   = data2_reg;
    assign bus.alu_ctrl    = ctrl_reg;
    assign bus.wb_addr     = wb_addr_reg;
    assign bus.wb_data     = result_reg;
    assign bus.zero_flag   = zero_reg;
    assign bus.dbg_data    = rf_read(bus.dbg_addr);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU, a timestamp-based
// reference model checked every cycle, and hand-computed writeback expectations.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            3'b010:  return a - b;
            3'b100:  return a * b;
            3'b101:  return a & b;
            3'b110:  return a << b;
            3'b111:  return a;
            default: return a + b;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_ctrl, bus.alu_data1, bus.alu_data2);

    function automatic logic [15:0] enc_imm(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [5:0] imm);
        return {op, rd, rs, 1'b1, imm};
    endfunction

    function automatic logic [15:0] enc_reg(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, 1'b0, rt, 3'b000};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: an accepted instruction at cycle t has operands visible
    // from t+2, writeback strobe at t+3, register/zero update visible from t+4.
    logic [15:0] m_rf [8];
    logic        chk_en = 1'b0;
    logic        pending = 1'b0;
    int          acc = 0;
    logic [15:0] p_a, p_b, p_res;
    logic [2:0]  p_ctrl, p_rd;
    logic [15:0] m_a, m_b, m_wb_data;
    logic [2:0]  m_ctrl, m_wb_addr;
    logic        m_zero;

    function automatic logic [15:0] m_read(input logic [2:0] a);
        return (a == 3'd0) ? 16'h0 : m_rf[a];
    endfunction

    function automatic logic [15:0] m_opb(input logic [15:0] w);
        return w[6] ? {10'b0, w[5:0]} : m_read(w[5:3]);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            chk_en    <= 1'b1;
            pending   <= 1'b0;
            for (int i = 0; i < 8; i++) m_rf[i] <= 16'h0;
            m_a       <= 16'h0;
            m_b       <= 16'h0;
            m_ctrl    <= 3'h0;
            m_wb_addr <= 3'h0;
            m_wb_data <= 16'h0;
            m_zero    <= 1'b0;
        end else begin
            if (!pending && bus.instr_valid) begin
                pending <= 1'b1;
                acc     <= cyc;
                p_a     <= m_read(bus.instr[9:7]);
                p_b     <= m_opb(bus.instr);
                p_ctrl  <= bus.instr[15:13];
                p_rd    <= bus.instr[12:10];
                p_res   <= alu_ref(bus.instr[15:13], m_read(bus.instr[9:7]), m_opb(bus.instr));
            end
            if (pending && cyc == acc + 1) begin
                m_a    <= p_a;
                m_b    <= p_b;
                m_ctrl <= p_ctrl;
            end
            if (pending && cyc == acc + 2) begin
                m_wb_addr <= p_rd;
                m_wb_data <= p_res;
            end
            if (pending && cyc == acc + 3) begin
                if (p_rd != 3'd0) m_rf[p_rd] <= p_res;
                m_zero  <= (p_res == 16'h0);
                pending <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model instr_ready", 32'(bus.instr_ready), 32'(!pending));
            chk("model wb_valid", 32'(bus.wb_valid), 32'(pending && cyc == acc + 3));
            chk("model wb_addr", 32'(bus.wb_addr), 32'(m_wb_addr));
            chk("model wb_data", 32'(bus.wb_data), 32'(m_wb_data));
            chk("model zero_flag", 32'(bus.zero_flag), 32'(m_zero));
            chk("model alu_data1", 32'(bus.alu_data1), 32'(m_a));
            chk("model alu_data2", 32'(bus.alu_data2), 32'(m_b));
            chk("model alu_ctrl", 32'(bus.alu_ctrl), 32'(m_ctrl));
            chk("model dbg_data", 32'(bus.dbg_data), 32'(m_read(bus.dbg_addr)));
        end
    end

    task automatic issue(input logic [15:0] w, input logic [15:0] exp_d, input logic exp_z, input string nm);
        int   acc_c;
        bit   got;
        logic [2:0] rd;
        rd    = w[12:10];
        acc_c = 0;
        @(posedge clk); #1;
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.instr_ready) begin
                got   = 1;
                acc_c = cyc;
            end
        end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        if (!got) begin
            chk({nm, " accept timeout"}, 32'd0, 32'd1);
            return;
        end
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.wb_valid) begin
                got = 1;
                chk({nm, " latency"}, 32'(cyc - acc_c), 32'd3);
                chk({nm, " wb_addr"}, 32'(bus.wb_addr), 32'(rd));
                chk({nm, " wb_data"}, 32'(bus.wb_data), 32'(exp_d));
            end
        end
        if (!got) chk({nm, " wb timeout"}, 32'd0, 32'd1);
        $display("instr %s: word=%h wb_data=%h", nm, w, bus.wb_data);
        @(posedge clk); #1;
        bus.dbg_addr = rd;
        @(negedge clk);
        chk({nm, " zero_flag"}, 32'(bus.zero_flag), 32'(exp_z));
        chk({nm, " dbg rd"}, 32'(bus.dbg_data), (rd == 3'd0) ? 32'd0 : 32'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0;
        bus.dbg_addr    = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < 8; a++) begin
            @(posedge clk); #1;
            bus.dbg_addr = 3'(a);
            @(negedge clk);
            chk("reset dbg", 32'(bus.dbg_data), 32'd0);
        end
        chk("reset instr_ready", 32'(bus.instr_ready), 32'd1);
        chk("reset wb_valid", 32'(bus.wb_valid), 32'd0);

        issue(enc_imm(3'b000, 3'd1, 3'd0, 6'd5), 16'h0005, 1'b0, "addi r1");
        issue(enc_imm(3'b000, 3'd2, 3'd0, 6'd7), 16'h0007, 1'b0, "addi r2");
        issue(enc_reg(3'b100, 3'd3, 3'd1, 3'd2), 16'd35,   1'b0, "mul r3");
        issue(enc_reg(3'b010, 3'd4, 3'd1, 3'd2), 16'hFFFE, 1'b0, "sub r4");
        issue(enc_reg(3'b010, 3'd5, 3'd1, 3'd1), 16'h0000, 1'b1, "sub r5");
        issue(enc_imm(3'b110, 3'd7, 3'd1, 6'd2), 16'd20,   1'b0, "shl r7");
        issue(enc_imm(3'b000, 3'd0, 3'd0, 6'd9), 16'd9,    1'b0, "add r0");
        issue(enc_reg(3'b111, 3'd2, 3'd4, 3'd0), 16'hFFFE, 1'b0, "pass r2");
        issue(enc_imm(3'b101, 3'd5, 3'd3, 6'h21), 16'h0021, 1'b0, "and r5");
        issue(enc_imm(3'b001, 3'd5, 3'd5, 6'h3F), 16'h0060, 1'b0, "add1 r5");

        // Back-to-back dependent increments of R1 with instr_valid held high
        @(posedge clk); #1;
        bus.instr_valid = 1'b1;
        bus.instr       = enc_imm(3'b000, 3'd1, 3'd1, 6'd1);
        for (int rel = 0; rel < 12; rel++) begin
            @(negedge clk);
            chk("stream instr_ready", 32'(bus.instr_ready), 32'(rel % 4 == 0));
            chk("stream wb_valid", 32'(bus.wb_valid), 32'(rel % 4 == 3));
            if (rel % 4 == 3) begin
                chk("stream wb_data", 32'(bus.wb_data), 32'(6 + rel / 4));
                $display("stream wb at rel %0d: wb_data=%h", rel, bus.wb_data);
            end
        end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;

        issue(enc_imm(3'b000, 3'd6, 3'd0, 6'h12), 16'h0012, 1'b0, "addi r6");
        issue(enc_imm(3'b110, 3'd6, 3'd6, 6'd8),  16'h1200, 1'b0, "shl r6");
        issue(enc_imm(3'b011, 3'd6, 3'd6, 6'h34), 16'h1234, 1'b0, "add3 r6");

        // Abort an in-flight add to R6 by resetting during EXEC
        @(posedge clk); #1;
        bus.instr_valid = 1'b1;
        bus.instr       = enc_imm(3'b000, 3'd6, 3'd6, 6'd1);
        @(negedge clk);
        chk("abort accept", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort wb_valid", 32'(bus.wb_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort wb_valid after", 32'(bus.wb_valid), 32'd0);
            if (k == 0) begin
                chk("abort dbg r6", 32'(bus.dbg_data), 32'd0);
                chk("abort instr_ready", 32'(bus.instr_ready), 32'd1);
                chk("abort alu_data1", 32'(bus.alu_data1), 32'd0);
                chk("abort alu_data2", 32'(bus.alu_data2), 32'd0);
                chk("abort alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
                chk("abort wb_addr", 32'(bus.wb_addr), 32'd0);
                chk("abort wb_data", 32'(bus.wb_data), 32'd0);
                chk("abort zero_flag", 32'(bus.zero_flag), 32'd0);
            end
        end
        $display("abort: dbg r6=%h wb_data=%h", bus.dbg_data, bus.wb_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
